fft_input_loader: RTL and testbench

//   Serial-to-parallel frame collector in front of the 32-point FFT first stage.

---
 rtl/fft_input_loader.sv | 138 +++++++++++++
 tb/tb_fft_input_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_loader.sv
// fft_input_loader
// Collects a valid/ready stream of signed real samples into a ping-pong pair of
// 32-slot register banks, optionally in bit-reversed slot order, and presents each
// completed frame on a flat bus. The frame stays stable until the consumer takes it.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// wr_bank_q    | bank currently being filled by the input stream
// rd_bank_q    | bank presented on o_frame
// full_q[b]    | bank b holds a complete frame not yet taken by the consumer
// count_q      | samples already written into the write bank (0..31)
// sof_err_q    | a partial frame was dropped by i_sof on the previous cycle
module fft_input_loader #(
  parameter int p_inputBits  = 9,
  parameter int p_points     = 32,
  parameter int p_bitReverse = 1
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [p_inputBits-1:0]          i_sample,
  input  logic                            i_valid,
  input  logic                            i_sof,
  output logic                            o_ready,
  output logic [p_points*p_inputBits-1:0] o_frame,
  output logic                            o_frame_valid,
  input  logic                            i_frame_ready,
  output logic                            o_sof_err,
  output logic [5:0]                      o_fill
);

  localparam logic [4:0] c_lastSlot = 5'd31;

  // Slot addressing for a 32-point frame: 5 address bits, mirrored when bit-reversing.
  function automatic logic [4:0] bitrev5(input logic [4:0] a);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) begin
      r[i] = a[4-i];
    end
    return r;
  endfunction

  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [1:0]             full_q, full_d;
  logic [4:0]             count_q, count_d;
  logic                   sof_err_q, sof_err_d;

  logic [p_inputBits-1:0] bank0_q [p_points];
  logic [p_inputBits-1:0] bank1_q [p_points];

  logic                   accept;
  logic                   sof_restart;
  logic                   complete;
  logic                   transfer;
  logic [4:0]             wr_index;
  logic [4:0]             wr_slot;

  // Handshake decode: acceptance, restart on a mid-frame i_sof, frame completion, frame transfer.
  always_comb begin
    o_ready     = !full_q[wr_bank_q];
    accept      = i_valid && o_ready;
    sof_restart = accept && i_sof && (count_q != 5'd0);
    complete    = accept && !sof_restart && (count_q == c_lastSlot);
    transfer    = full_q[rd_bank_q] && i_frame_ready;
    // A restart rewrites the dropped frame from sample 0, whatever count had reached.
    wr_index    = sof_restart ? 5'd0 : count_q;
    wr_slot     = (p_bitReverse != 0) ? bitrev5(wr_index) : wr_index;
  end

  // Next-state for bank pointers, full flags, sample count and the restart pulse.
  // Completion and transfer always target different banks, so both flag updates can apply.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    count_d   = count_q;
    sof_err_d = sof_restart;

    if (accept) begin
      if (sof_restart) begin
        count_d = 5'd1;
      end else if (complete) begin
        count_d   = 5'd0;
        wr_bank_d = !wr_bank_q;
      end else begin
        count_d = count_q + 5'd1;
      end
    end

    if (complete) begin
      full_d[wr_bank_q] = 1'b1;
    end

    if (transfer) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  // Control state registers with synchronous reset; drops all frames and partial data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      count_q   <= 5'd0;
      sof_err_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      count_q   <= count_d;
      sof_err_q <= sof_err_d;
    end
  end

  // Sample storage, written raw into the selected slot of the write bank; contents are not reset.
  always_ff @(posedge CLK) begin
    if (accept && !wr_bank_q) begin
      bank0_q[wr_slot] <= i_sample;
    end
    if (accept && wr_bank_q) begin
      bank1_q[wr_slot] <= i_sample;
    end
  end

  // Output frame mux straight from the read bank, plus status outputs.
  always_comb begin
    o_frame = '0;
    for (int k = 0; k < p_points; k++) begin
      o_frame[k*p_inputBits +: p_inputBits] = rd_bank_q ? bank1_q[k] : bank0_q[k];
    end
    o_frame_valid = full_q[rd_bank_q];
    o_sof_err     = sof_err_q;
    o_fill        = {1'b0, count_q};
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader
// Directed bench: two loaders (bit-reversed and natural order) share one stimulus stream,
// so their control state stays in lockstep while their slot orderings differ.
module tb_fft_input_loader;

  localparam int W = 9;
  localparam int N = 32;

  logic           CLK = 1'b0;
  logic           RST;
  logic [W-1:0]   i_sample;
  logic           i_valid;
  logic           i_sof;
  logic           i_frame_ready;

  logic           o_ready_br, o_ready_nr;
  logic [N*W-1:0] o_frame_br, o_frame_nr;
  logic           o_frame_valid_br, o_frame_valid_nr;
  logic           o_sof_err_br, o_sof_err_nr;
  logic [5:0]     o_fill_br, o_fill_nr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = !CLK;

  fft_input_loader #(.p_inputBits(W), .p_points(N), .p_bitReverse(1)) dut_br (
    .CLK(CLK), .RST(RST), .i_sample(i_sample), .i_valid(i_valid), .i_sof(i_sof),
    .o_ready(o_ready_br), .o_frame(o_frame_br), .o_frame_valid(o_frame_valid_br),
    .i_frame_ready(i_frame_ready), .o_sof_err(o_sof_err_br), .o_fill(o_fill_br)
  );

  fft_input_loader #(.p_inputBits(W), .p_points(N), .p_bitReverse(0)) dut_nr (
    .CLK(CLK), .RST(RST), .i_sample(i_sample), .i_valid(i_valid), .i_sof(i_sof),
    .o_ready(o_ready_nr), .o_frame(o_frame_nr), .o_frame_valid(o_frame_valid_nr),
    .i_frame_ready(i_frame_ready), .o_sof_err(o_sof_err_nr), .o_fill(o_fill_nr)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] slot_of(input logic [N*W-1:0] f, input int k);
    return f[k*W +: W];
  endfunction

  function automatic logic [31:0] s9(input int v);
    logic [W-1:0] t;
    t = W'(v);
    return {23'd0, t};
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int v, input logic sof);
    i_valid  = 1'b1;
    i_sample = W'(v);
    i_sof    = sof;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  initial begin
    RST = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_sample = '0; i_frame_ready = 1'b0;
    #1;

    // 1: reset
    tick(); tick();
    RST = 1'b0;
    check_val("rst_ready", {31'd0, o_ready_br}, 1);
    check_val("rst_valid", {31'd0, o_frame_valid_br}, 0);
    check_val("rst_fill", {26'd0, o_fill_nr}, 0);
    check_val("rst_sof_err", {31'd0, o_sof_err_nr}, 0);

    // 2: 0..31 with i_frame_ready low
    for (int n = 0; n < N; n++) begin
      drive(n, n == 0);
      if (n == N-1) check_val("t2_valid_before", {31'd0, o_frame_valid_br}, 0);
      tick();
      if (n == 0) check_val("t2_sof_at_zero", {31'd0, o_sof_err_br}, 0);
    end
    idle();
    check_val("t2_valid_after", {31'd0, o_frame_valid_br}, 1);
    check_val("t2_br_slot0", {23'd0, slot_of(o_frame_br, 0)}, 0);
    check_val("t2_br_slot16", {23'd0, slot_of(o_frame_br, 16)}, 1);
    check_val("t2_br_slot8", {23'd0, slot_of(o_frame_br, 8)}, 2);
    check_val("t2_br_slot24", {23'd0, slot_of(o_frame_br, 24)}, 3);
    check_val("t2_br_slot31", {23'd0, slot_of(o_frame_br, 31)}, 31);
    check_val("t2_nr_slot5", {23'd0, slot_of(o_frame_nr, 5)}, 5);
    tick();
    check_val("t2_held", {23'd0, slot_of(o_frame_br, 16)}, 1);
    i_frame_ready = 1'b1;
    tick();
    check_val("t2_drained", {31'd0, o_frame_valid_nr}, 0);

    // 3: natural order, -256..-225, consumer always ready
    for (int n = 0; n < N; n++) begin
      drive(-256 + n, n == 0);
      tick();
      if (n < N-1 && o_frame_valid_nr) check_val("t3_early_valid", {31'd0, o_frame_valid_nr}, 0);
    end
    idle();
    check_val("t3_valid", {31'd0, o_frame_valid_nr}, 1);
    for (int k = 0; k < N; k++) begin
      check_val($sformatf("t3_nr_slot%0d", k), {23'd0, slot_of(o_frame_nr, k)}, s9(-256 + k));
    end
    check_val("t3_br_slot16", {23'd0, slot_of(o_frame_br, 16)}, s9(-255));
    tick();
    check_val("t3_valid_one_cycle", {31'd0, o_frame_valid_nr}, 0);

    // 4: 70 samples with consumer stalled
    i_frame_ready = 1'b0;
    for (int n = 0; n < 64; n++) begin
      drive(100 + n, 1'b0);
      tick();
    end
    check_val("t4_ready_low", {31'd0, o_ready_br}, 0);
    check_val("t4_valid", {31'd0, o_frame_valid_br}, 1);
    drive(164, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val("t4_stall_ready", {31'd0, o_ready_nr}, 0);
      check_val("t4_stall_fill", {26'd0, o_fill_nr}, 0);
    end
    for (int k = 0; k < N; k++) begin
      check_val($sformatf("t4_f1_slot%0d", k), {23'd0, slot_of(o_frame_nr, k)}, s9(100 + k));
    end
    i_frame_ready = 1'b1;
    tick();
    i_frame_ready = 1'b0;
    check_val("t4_ready_back", {31'd0, o_ready_br}, 1);
    check_val("t4_fill_not_taken", {26'd0, o_fill_br}, 0);
    check_val("t4_f2_valid", {31'd0, o_frame_valid_br}, 1);
    for (int k = 0; k < N; k++) begin
      check_val($sformatf("t4_f2_slot%0d", k), {23'd0, slot_of(o_frame_nr, k)}, s9(132 + k));
    end
    tick();
    check_val("t4_s65_taken", {26'd0, o_fill_br}, 1);
    for (int n = 65; n < 70; n++) begin
      drive(100 + n, 1'b0);
      tick();
    end
    idle();
    check_val("t4_fill6", {26'd0, o_fill_nr}, 6);

    // 5: completion coincides with transfer
    for (int n = 70; n < 96; n++) begin
      drive(100 + n, 1'b0);
      if (n == 95) begin
        check_val("t5_ready_pre", {31'd0, o_ready_br}, 1);
        i_frame_ready = 1'b1;
      end
      tick();
    end
    idle();
    i_frame_ready = 1'b0;
    check_val("t5_valid", {31'd0, o_frame_valid_nr}, 1);
    check_val("t5_ready", {31'd0, o_ready_nr}, 1);
    check_val("t5_fill", {26'd0, o_fill_nr}, 0);
    for (int k = 0; k < N; k++) begin
      check_val($sformatf("t5_slot%0d", k), {23'd0, slot_of(o_frame_nr, k)}, s9(164 + k));
    end
    i_frame_ready = 1'b1;
    tick();
    i_frame_ready = 1'b0;
    check_val("t5_drained", {31'd0, o_frame_valid_br}, 0);

    // 6: mid-frame i_sof restart, then reset mid-frame with a full bank
    for (int n = 0; n < 10; n++) begin
      drive(20 + n, n == 0);
      tick();
    end
    check_val("t6_fill10", {26'd0, o_fill_br}, 10);
    drive(5, 1'b1);
    tick();
    check_val("t6_sof_err", {31'd0, o_sof_err_br}, 1);
    check_val("t6_fill1", {26'd0, o_fill_br}, 1);
    for (int j = 0; j < 31; j++) begin
      drive(40 + j, 1'b0);
      tick();
      if (j == 0) check_val("t6_sof_err_pulse", {31'd0, o_sof_err_nr}, 0);
    end
    idle();
    check_val("t6_valid", {31'd0, o_frame_valid_nr}, 1);
    check_val("t6_nr_slot0", {23'd0, slot_of(o_frame_nr, 0)}, 5);
    check_val("t6_nr_slot1", {23'd0, slot_of(o_frame_nr, 1)}, 40);
    check_val("t6_nr_slot31", {23'd0, slot_of(o_frame_nr, 31)}, 70);
    check_val("t6_br_slot0", {23'd0, slot_of(o_frame_br, 0)}, 5);
    check_val("t6_br_slot16", {23'd0, slot_of(o_frame_br, 16)}, 40);
    for (int n = 0; n < 7; n++) begin
      drive(n, 1'b0);
      tick();
    end
    idle();
    check_val("t6_fill7", {26'd0, o_fill_nr}, 7);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_val("t6_rst_fill", {26'd0, o_fill_nr}, 0);
    check_val("t6_rst_valid", {31'd0, o_frame_valid_nr}, 0);
    check_val("t6_rst_ready", {31'd0, o_ready_br}, 1);
    check_val("t6_rst_valid_br", {31'd0, o_frame_valid_br}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
